mux_stream_arb: RTL
===================

// Module: mux_stream_arb
// PURPOSE
//  N-channel valid/ready stream multiplexer with packet locking and a registered output stage.
//  Source choice is selectable per packet: fixed select (sel_i) or round-robin arbitration.
//  Sits between N producer streams and one consumer; successor to the registered N:1 mux wrapper.
// PARAMETERS (defaults come from mux_pkg)
//  WIDTH   32  data width per channel
//  N       4   channel count, N >= 1
//  SEL_W   (N<=1)?1:$clog2(N)  select/index width (derived, not overridable)
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            asynchronous active-low reset
//  mode_i       in   1            0 = fixed select, 1 = round-robin
//  sel_i        in   SEL_W        source index used in mode 0
//  in_valid_i   in   N            per-channel valid
//  in_data_i    in   WIDTH x [N]  per-channel data, unpacked array
//  in_last_i    in   N            per-channel end-of-packet
//  in_ready_o   out  N            per-channel ready; at most one bit set
//  out_valid_o  out  1            output valid
//  out_data_o   out  WIDTH        output data
//  out_last_o   out  1            output end-of-packet
//  out_sel_o    out  SEL_W        channel index that produced the current output beat
//  out_ready_i  in   1            consumer ready
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, rr_ptr=0, out_valid_o/out_data_o/out_last_o/out_sel_o=0,
//    in_ready_o=0. Reset mid-packet drops the packet; no partial beats are emitted after release.
//  - Transfer rules: input beat k transfers when in_valid_i[k] & in_ready_o[k];
//    output beat transfers when out_valid_o & out_ready_i.
//  - FSM, two states:
//    IDLE:   grant g is combinational.
//            mode 0: g = sel_i if sel_i < N and in_valid_i[sel_i]; otherwise no grant.
//            mode 1: g = first valid channel at or after rr_ptr, modulo N.
//            Beat accepted with last=0 -> LOCKED(g). Beat accepted with last=1 -> stay IDLE.
//    LOCKED: g is held. mode_i and sel_i are ignored. Other channels see in_ready_o=0.
//            Accepted beat with last=1 -> IDLE.
//  - rr_ptr <= (g+1) mod N on acceptance of any last=1 beat, in both modes.
//  - in_ready_o[k] = (k==g) & grant_valid & stage_can_accept. Never asserted for a non-granted channel.
//  - Latency: an accepted input beat appears on out_* on the next clock edge.
//    out_* hold stable while out_valid_o & !out_ready_i.
//  - Simultaneous output drain and input accept in the same cycle: sustains 1 beat/cycle with no bubble.
//  - N==1: mode and sel are ignored; channel 0 is always granted; out_sel_o=0.
//  - sel_i >= N (non-power-of-2 N): no grant, nothing transfers, no error is raised.
// CONFIGURATION
//  MUX_STREAM_ARB_SKID_EN
//   - Defined: 2-entry skid buffer. stage_can_accept is a registered signal (skid not full),
//     so there is no combinational path from out_ready_i to in_ready_o. Full throughput.
//     Up to 2 beats in flight after out_ready_i falls.
//   - Undefined: single output register. stage_can_accept = !out_valid_o | out_ready_i (combinational).
//     Full throughput. At most 1 beat held.
// STRUCTURE
//  - mux_pkg holds: WIDTH, N, SEL_W, typedef enum {IDLE, LOCKED} arb_state_e,
//    typedef enum {MODE_SEL, MODE_RR} mux_mode_e.
//  - One sub-module: mux_rr_pick. Purely combinational: (req[N], ptr) -> (gnt_idx, gnt_valid).
//    Top holds FSM, rr_ptr and the output/skid stage.
// TESTING
//  1 Reset: rst_n=0 mid-packet on ch2 -> all outputs 0 immediately; after release, ch2 must restart,
//    out_valid_o=0 until a new accept.
//  2 Mode 0, sel_i=1, ch1 sends 3 beats 0xA0..0xA2 (last on 3rd), ch0 valid throughout
//    -> out_data 0xA0,0xA1,0xA2 on consecutive cycles, out_sel_o=1, in_ready_o[0]=0 throughout.
//  3 Lock: sel_i changes 1->3 after first beat of ch1 packet -> packet completes from ch1;
//    ch3 is granted only after the last beat.
//  4 Mode 1, all 4 channels valid with 1-beat packets -> out_sel_o sequence 0,1,2,3,0.
//  5 Backpressure: out_ready_i=0 for 5 cycles mid-stream -> out_* stable;
//    no beat lost or duplicated (scoreboard); <=1 beat held (skid off) or <=2 (skid on).
//  6 sel_i=3 with N=3 -> in_ready_o=0 and out_valid_o=0 for 10 cycles.
//    Then sel_i=2 -> ch2 data passes with 1-cycle latency.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared parameters and types for mux_stream_arb
package mux_pkg;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = (N <= 1) ? 1 : $clog2(N);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

endpackage

// File: rtl/mux_rr_pick.sv
// rtl/mux_rr_pick.sv - combinational round-robin picker: first requester at or after ptr, modulo N
module mux_rr_pick #(
  parameter int N = mux_pkg::N
) (
  input  logic [N-1:0]                          req,
  input  logic [((N <= 1) ? 1 : $clog2(N))-1:0] ptr,
  output logic [((N <= 1) ? 1 : $clog2(N))-1:0] gnt_idx,
  output logic                                  gnt_valid
);

  localparam int SW = (N <= 1) ? 1 : $clog2(N);

  logic [SW-1:0] idx;

  // Walk the channels starting at ptr and keep the first one requesting.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = SW'((int'(ptr) + i) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mux_stream_arb.sv
// rtl/mux_stream_arb.sv - N:1 packet-locking stream mux; MUX_STREAM_ARB_SKID_EN selects a 2-entry skid output stage
module mux_stream_arb #(
  parameter int WIDTH = mux_pkg::WIDTH,
  parameter int N     = mux_pkg::N
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  mode_i,
  input  logic [((N <= 1) ? 1 : $clog2(N))-1:0] sel_i,
  input  logic [N-1:0]                          in_valid_i,
  input  logic [WIDTH-1:0]                      in_data_i [N],
  input  logic [N-1:0]                          in_last_i,
  output logic [N-1:0]                          in_ready_o,
  output logic                                  out_valid_o,
  output logic [WIDTH-1:0]                      out_data_o,
  output logic                                  out_last_o,
  output logic [((N <= 1) ? 1 : $clog2(N))-1:0] out_sel_o,
  input  logic                                  out_ready_i
);

  localparam int SEL_W = (N <= 1) ? 1 : $clog2(N);

  mux_pkg::arb_state_e state;
  logic [SEL_W-1:0]    lock_idx;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_valid;
  logic [SEL_W-1:0]    grant;
  logic                grant_valid;
  logic                stage_can_accept;
  logic                accept;
  logic [WIDTH-1:0]    beat_data;
  logic                beat_last;

  mux_rr_pick #(.N(N)) u_rr_pick (
    .req       (in_valid_i),
    .ptr       (rr_ptr),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // Grant: held while a packet is open, otherwise chosen by mode.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (state == mux_pkg::LOCKED) begin
      grant       = lock_idx;
      grant_valid = 1'b1;
    end else if (N == 1) begin
      grant_valid = in_valid_i[0];
    end else if (mux_pkg::mux_mode_e'(mode_i) == mux_pkg::MODE_RR) begin
      grant       = rr_idx;
      grant_valid = rr_valid;
    end else if (int'(sel_i) < N) begin
      grant       = sel_i;
      grant_valid = in_valid_i[sel_i];
    end
  end

  // Only the granted channel may see ready; held low while in reset.
  always_comb begin
    in_ready_o = '0;
    for (int k = 0; k < N; k++) begin
      in_ready_o[k] = rst_n && grant_valid && stage_can_accept && (grant == SEL_W'(k));
    end
  end

  // Beat presented by the granted channel and whether it transfers this cycle.
  always_comb begin
    beat_data = in_data_i[grant];
    beat_last = in_last_i[grant];
    accept    = |(in_valid_i & in_ready_o);
  end

  // Packet lock and round-robin pointer advance on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= mux_pkg::IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      if (beat_last) begin
        state  <= mux_pkg::IDLE;
        rr_ptr <= (int'(grant) == N - 1) ? '0 : grant + SEL_W'(1);
      end else begin
        state    <= mux_pkg::LOCKED;
        lock_idx <= grant;
      end
    end
  end

`ifdef MUX_STREAM_ARB_SKID_EN

  logic [1:0]       fill;
  logic [1:0]       fill_next;
  logic             can_q;
  logic             pop;
  logic [WIDTH-1:0] skid_data;
  logic             skid_last;
  logic [SEL_W-1:0] skid_sel;

  assign pop              = out_valid_o && out_ready_i;
  assign stage_can_accept = can_q;

  // Occupancy after this cycle's push/pop; the accept flag is registered from it.
  always_comb begin
    fill_next = fill + {1'b0, accept} - {1'b0, pop};
  end

  // Head register drives out_*; the skid slot catches one beat while the head stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill        <= 2'd0;
      can_q       <= 1'b1;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_sel_o   <= '0;
      skid_data   <= '0;
      skid_last   <= 1'b0;
      skid_sel    <= '0;
    end else begin
      fill  <= fill_next;
      can_q <= (fill_next != 2'd2);
      if (accept && ((fill == 2'd0) || pop)) begin
        out_valid_o <= 1'b1;
        out_data_o  <= beat_data;
        out_last_o  <= beat_last;
        out_sel_o   <= grant;
      end else if (accept) begin
        skid_data <= beat_data;
        skid_last <= beat_last;
        skid_sel  <= grant;
      end else if (pop && (fill == 2'd2)) begin
        out_data_o <= skid_data;
        out_last_o <= skid_last;
        out_sel_o  <= skid_sel;
      end else if (pop) begin
        out_valid_o <= 1'b0;
      end
    end
  end

`else

  assign stage_can_accept = !out_valid_o || out_ready_i;

  // Single output register: load on accept, clear valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_sel_o   <= '0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_data_o  <= beat_data;
      out_last_o  <= beat_last;
      out_sel_o   <= grant;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`endif

endmodule
